camera_pick_scheduler: RTL and testbench
========================================

# camera_pick_scheduler

Sits between the camera UART frame parser and the robot-arm motion controller. Accepts parsed target frames (X, Y, warehouse number, colour, corrected angle), filters invalid and duplicate targets, and buffers them in a small FIFO. Dispatches targets one at a time to the arm over a req/ack/done handshake, with a watchdog timeout on arm completion.

## Interface
- FIFO_DEPTH, 4, target buffer depth; power of two, 2..16
- TIMEOUT_CYC, 500_000_000, cycles allowed from ack to done (10 s at 50 MHz)
- Clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = accept frames and dispatch; 0 = ignore cam_valid and hold in IDLE (an in-flight job completes)
- flush  in  1  1-cycle pulse: empty FIFO, clear duplicate register
- cam_valid  in  1  1-cycle pulse, frame fields valid
- cam_x  in  9  target X
- cam_y  in  8  target Y
- cam_wh  in  4  warehouse number; 0 = invalid
- cam_color  in  4  colour code
- cam_angle  in  12  corrected angle
- arm_req  out  1  job request
- arm_x / arm_y / arm_wh / arm_color / arm_angle  out  9/8/4/4/12  job fields, stable while arm_req or WAIT_DONE
- arm_ack  in  1  arm accepted job
- arm_done  in  1  1-cycle pulse, job finished
- busy  out  1  FSM not in IDLE
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- drop_cnt  out  8  saturating count of frames rejected (full, invalid, duplicate)
- timeout_err  out  1  1-cycle pulse on watchdog expiry

## Operation
- Ingest, evaluated on cam_valid && enable, in priority order:
  - cam_wh == 0: reject.
  - {x, y, wh} equals the last pushed entry and dup_valid == 1: reject.
  - FIFO full: reject.
  - Otherwise push the 37-bit entry, store {x, y, wh} in the duplicate register and set dup_valid.
- Every reject increments drop_cnt, saturating at 255.
- Push and pop in the same cycle are both performed when legal.
  - A push into a full FIFO is rejected even if a pop occurs that cycle.
- Pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.
- flush clears pointers, count and dup_valid. It has priority over a same-cycle push and does not affect an in-flight job.
- dup_valid is also cleared when a dispatched job completes, whether by done or by timeout. The same target may be re-queued after the arm has serviced it.
- Dispatch FSM:
  - IDLE: if enable && count != 0, go to LOAD.
  - LOAD: pop the head into the arm_* registers, go to REQ.
  - REQ: arm_req = 1. On arm_ack, drop arm_req next cycle, clear the watchdog, go to WAIT_DONE.
  - WAIT_DONE: on arm_done, go to IDLE. When the watchdog reaches TIMEOUT_CYC-1, pulse timeout_err and go to IDLE; the job is discarded.
  - Unused encodings go to IDLE.
- The REQ state has no timeout. arm_req holds until arm_ack.
- arm_done outside WAIT_DONE is ignored. arm_ack outside REQ is ignored.
- The watchdog is 32 bits wide and counts only in WAIT_DONE.

## Timing
- Reset values:
  - arm_req = 0, busy = 0, timeout_err = 0
  - arm_* fields = 0, fifo_count = 0, drop_cnt = 0
  - FSM in IDLE, dup_valid = 0, watchdog = 0
- Reset mid-job drops arm_req asynchronously and loses all queued entries.
- Latency, cam_valid sampled at edge N with an empty FIFO and FSM in IDLE:
  - fifo_count = 1 after edge N.
  - LOAD after edge N+1.
  - arm_req = 1 with valid fields after edge N+2, and fifo_count = 0 at the same time.
- Handshake:
  - arm_ack sampled high at edge M gives arm_req = 0 after M.
  - A combinational ack in the first REQ cycle gives a 1-cycle req.
- arm_done sampled at edge D puts the FSM in IDLE after D. With FIFO non-empty, the next arm_req rises after D+2.
- Timeout: timeout_err is high for exactly the one cycle after TIMEOUT_CYC edges in WAIT_DONE.
- All outputs are registered.

## Test plan
- Single frame: cam_valid with x=0x123, y=0x45, wh=3, color=2, angle=0x2A0.
  - arm_req rises 2 cycles later with identical fields.
  - ack, then done: busy falls, fifo_count = 0.
- Overflow: 6 distinct frames with wh=1..6 while the arm holds ack low.
  - The first is dispatched, 4 are buffered, the 6th is rejected: drop_cnt = 1.
  - Completion order matches wh order 1..5.
- Filters:
  - A frame with wh=0: drop_cnt +1.
  - The same valid frame twice: the second is dropped.
  - Same frame again after arm_done: accepted.
- Timeout (TIMEOUT_CYC=100): ack, no done.
  - timeout_err pulses exactly 100 cycles after entering WAIT_DONE.
  - The next queued job is requested 2 cycles after that.
- Simultaneous push/pop with count=FIFO_DEPTH in the LOAD cycle: push rejected, count = FIFO_DEPTH-1. flush during a push: count = 0.
- Reset asserted in WAIT_DONE: arm_req, busy, fifo_count and drop_cnt are all 0 immediately. A later frame dispatches normally.

Source files
------------

// File: rtl/camera_pick_scheduler_if.sv
// Camera-to-arm bus bundle for camera_pick_scheduler.
// The master side is the scheduler: it consumes parsed camera frames and
// drives jobs toward the arm. The slave side is the environment, meaning the
// frame parser together with the motion controller.
interface camera_pick_scheduler_if;

   // Parsed target frame from the camera UART parser
   logic        cam_valid;
   logic [8:0]  cam_x;
   logic [7:0]  cam_y;
   logic [3:0]  cam_wh;
   logic [3:0]  cam_color;
   logic [11:0] cam_angle;

   // Job handshake toward the motion controller
   logic        arm_req;
   logic [8:0]  arm_x;
   logic [7:0]  arm_y;
   logic [3:0]  arm_wh;
   logic [3:0]  arm_color;
   logic [11:0] arm_angle;
   logic        arm_ack;
   logic        arm_done;

   modport master (
      input  cam_valid, cam_x, cam_y, cam_wh, cam_color, cam_angle,
      input  arm_ack, arm_done,
      output arm_req, arm_x, arm_y, arm_wh, arm_color, arm_angle
   );

   modport slave (
      output cam_valid, cam_x, cam_y, cam_wh, cam_color, cam_angle,
      output arm_ack, arm_done,
      input  arm_req, arm_x, arm_y, arm_wh, arm_color, arm_angle
   );

endinterface

// File: rtl/camera_pick_scheduler.sv
// camera_pick_scheduler: filters parsed camera targets, buffers them in a
// small FIFO and dispatches them one at a time to the robot arm over a
// req/ack/done handshake. A watchdog limits how long a job may run.
module camera_pick_scheduler #(
   parameter int          FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
   input  logic                        Clk,
   input  logic                        rst_n,
   input  logic                        enable_i,
   input  logic                        flush_i,
   camera_pick_scheduler_if.master     bus,
   output logic                        busy_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
   output logic [7:0]                  drop_cnt_o,
   output logic                        timeout_err_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 37;
   localparam int KW = 21;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [31:0]   WD_LAST    = 32'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOAD      = 2'd1,
      S_REQ       = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_e;

   state_e           state_q, state_d;

   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;

   logic [KW-1:0]    dupKey_q, dupKey_d;
   logic             dupValid_q, dupValid_d;
   logic [7:0]       dropCnt_q, dropCnt_d;
   logic [31:0]      wd_q, wd_d;

   logic [EW-1:0]    armEntry_q;
   logic             armReq_q;
   logic             busy_q;
   logic             timeoutErr_q;

   logic             camFire;
   logic [KW-1:0]    camKey;
   logic [EW-1:0]    camEntry;
   logic             isInvalid;
   logic             isDup;
   logic             isFull;
   logic             doPush;
   logic             doReject;

   logic             doPop;
   logic             wdClear;
   logic             jobEnd;
   logic             timeoutHit;

   // Frame ingest filter: warehouse 0 is invalid, a repeat of the last pushed
   // target is a duplicate, and a full FIFO rejects even if a pop happens in
   // the same cycle. A flush swallows the frame without counting it as a drop.
   always_comb begin
      camFire   = bus.cam_valid && enable_i;
      camKey    = {bus.cam_x, bus.cam_y, bus.cam_wh};
      camEntry  = {bus.cam_x, bus.cam_y, bus.cam_wh, bus.cam_color, bus.cam_angle};
      isInvalid = (bus.cam_wh == 4'd0);
      isDup     = dupValid_q && (camKey == dupKey_q);
      isFull    = (count_q == FULL_COUNT);
      doPush    = camFire && !flush_i && !isInvalid && !isDup && !isFull;
      doReject  = camFire && !flush_i && (isInvalid || isDup || isFull);
   end

   // Dispatch FSM next-state logic. LOAD re-checks the count because a flush
   // in the IDLE->LOAD cycle may have emptied the FIFO; in that case nothing
   // is popped and the FSM quietly returns to IDLE.
   always_comb begin
      state_d    = state_q;
      doPop      = 1'b0;
      wdClear    = 1'b0;
      jobEnd     = 1'b0;
      timeoutHit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable_i && (count_q != '0)) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (count_q != '0) begin
               doPop   = 1'b1;
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (bus.arm_ack) begin
               wdClear = 1'b1;
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (bus.arm_done) begin
               jobEnd  = 1'b1;
               state_d = S_IDLE;
            end else if (wd_q == WD_LAST) begin
               jobEnd     = 1'b1;
               timeoutHit = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO pointer and occupancy update; flush wins over any push or pop.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
         end
         if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
         end
         count_d = count_q + CW'(doPush) - CW'(doPop);
      end
   end

   // Duplicate register, drop counter and watchdog next-state. A push in the
   // same cycle as a job completion keeps the new target as the duplicate key,
   // since it is now the most recently pushed entry.
   always_comb begin
      dupKey_d   = dupKey_q;
      dupValid_d = dupValid_q;
      dropCnt_d  = dropCnt_q;
      wd_d       = wd_q;
      if (flush_i) begin
         dupValid_d = 1'b0;
      end else if (doPush) begin
         dupKey_d   = camKey;
         dupValid_d = 1'b1;
      end else if (jobEnd) begin
         dupValid_d = 1'b0;
      end
      if (doReject && (dropCnt_q != 8'hFF)) begin
         dropCnt_d = dropCnt_q + 8'd1;
      end
      if (wdClear) begin
         wd_d = '0;
      end else if ((state_q == S_WAIT_DONE) && !jobEnd) begin
         wd_d = wd_q + 32'd1;
      end
   end

   // Control and status registers; all outputs come straight from flops.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
         dupKey_q     <= '0;
         dupValid_q   <= 1'b0;
         dropCnt_q    <= '0;
         wd_q         <= '0;
         armReq_q     <= 1'b0;
         busy_q       <= 1'b0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         count_q      <= count_d;
         dupKey_q     <= dupKey_d;
         dupValid_q   <= dupValid_d;
         dropCnt_q    <= dropCnt_d;
         wd_q         <= wd_d;
         armReq_q     <= (state_d == S_REQ);
         busy_q       <= (state_d != S_IDLE);
         timeoutErr_q <= timeoutHit;
      end
   end

   // Job field register, loaded from the FIFO head in LOAD and held stable
   // through REQ and WAIT_DONE.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         armEntry_q <= '0;
      end else if (doPop) begin
         armEntry_q <= mem_q[rdPtr_q];
      end
   end

   // Target storage; contents are only meaningful behind the count, so no reset.
   always_ff @(posedge Clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= camEntry;
      end
   end

   assign bus.arm_req   = armReq_q;
   assign bus.arm_x     = armEntry_q[36:28];
   assign bus.arm_y     = armEntry_q[27:20];
   assign bus.arm_wh    = armEntry_q[19:16];
   assign bus.arm_color = armEntry_q[15:12];
   assign bus.arm_angle = armEntry_q[11:0];

   assign busy_o        = busy_q;
   assign fifo_count_o  = count_q;
   assign drop_cnt_o    = dropCnt_q;
   assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_camera_pick_scheduler.sv
// Testbench for camera_pick_scheduler: a scoreboard queue holds every frame
// expected to reach the arm, in order, and each dispatched job is compared
// against its head.
module tb_camera_pick_scheduler;

   localparam int          FIFO_DEPTH  = 4;
   localparam int unsigned TIMEOUT_CYC = 100;

   typedef struct packed {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [3:0]  wh;
      logic [3:0]  color;
      logic [11:0] angle;
   } frame_t;

   logic       Clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       flush;
   logic       busy;
   logic [2:0] fifoCount;
   logic [7:0] dropCnt;
   logic       timeoutErr;

   camera_pick_scheduler_if bus();

   camera_pick_scheduler #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .Clk           (Clk),
      .rst_n         (rst_n),
      .enable_i      (enable),
      .flush_i       (flush),
      .bus           (bus),
      .busy_o        (busy),
      .fifo_count_o  (fifoCount),
      .drop_cnt_o    (dropCnt),
      .timeout_err_o (timeoutErr)
   );

   // 100 MHz reference clock
   always #5 Clk = ~Clk;

   frame_t expQ[$];
   int     testsRun    = 0;
   int     testsFailed = 0;
   int     expDrop     = 0;

   function automatic frame_t mkFrame(input logic [8:0] x, input logic [7:0] y,
                                      input logic [3:0] wh, input logic [3:0] c,
                                      input logic [11:0] a);
      frame_t f;
      f.x = x; f.y = y; f.wh = wh; f.color = c; f.angle = a;
      return f;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One-cycle cam_valid pulse; the bench records what it expects to happen.
   task automatic applyStimulus(input frame_t f, input bit expectAccept, input bit expectDrop);
      bus.cam_valid = 1'b1;
      bus.cam_x     = f.x;
      bus.cam_y     = f.y;
      bus.cam_wh    = f.wh;
      bus.cam_color = f.color;
      bus.cam_angle = f.angle;
      tick();
      bus.cam_valid = 1'b0;
      if (expectAccept) expQ.push_back(f);
      if (expectDrop)   expDrop++;
   endtask

   task automatic waitReq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (bus.arm_req === 1'b1) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   // Arm responder: wait for a request, score its fields, ack in the first
   // REQ cycle (one-cycle request), then finish the job with done.
   task automatic serviceJob(input string name);
      bit     ok;
      frame_t exp;
      frame_t got;
      waitReq(ok);
      testsRun++;
      if (!ok) begin
         testsFailed++;
         $display("[TB] FAIL %s_req: arm_req never rose", name);
         return;
      end
      got = {bus.arm_x, bus.arm_y, bus.arm_wh, bus.arm_color, bus.arm_angle};
      if (expQ.size() == 0) begin
         testsFailed++;
         $display("[TB] FAIL %s_fields: unexpected job %h", name, got);
      end else begin
         exp = expQ.pop_front();
         if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s_fields: got %h expected %h", name, got, exp);
         end
      end
      bus.arm_ack = 1'b1;
      tick();
      bus.arm_ack = 1'b0;
      testsRun++;
      if (bus.arm_req !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL %s_req_drop: got %b expected 0", name, bus.arm_req);
      end
      tick();
      bus.arm_done = 1'b1;
      tick();
      bus.arm_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; flush = 1'b0;
      bus.cam_valid = 1'b0; bus.cam_x = '0; bus.cam_y = '0; bus.cam_wh = '0;
      bus.cam_color = '0; bus.cam_angle = '0; bus.arm_ack = 1'b0; bus.arm_done = 1'b0;
      repeat (3) tick();
      testsRun++; if (bus.arm_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req: got %b expected 0", bus.arm_req); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      testsRun++; if (fifoCount !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_count: got %0d expected 0", fifoCount); end
      testsRun++; if (dropCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_drop: got %0d expected 0", dropCnt); end
      testsRun++; if (timeoutErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeoutErr); end
      testsRun++;
      if ({bus.arm_x, bus.arm_y, bus.arm_wh, bus.arm_color, bus.arm_angle} !== 37'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_fields: got %h expected 0",
                  {bus.arm_x, bus.arm_y, bus.arm_wh, bus.arm_color, bus.arm_angle});
      end
      rst_n = 1'b1;
      tick();
      enable = 1'b1;
   endtask

   task automatic test_single_frame();
      frame_t f, exp, got;
      f = mkFrame(9'h123, 8'h45, 4'd3, 4'd2, 12'h2A0);
      applyStimulus(f, 1'b1, 1'b0);
      testsRun++; if (fifoCount !== 3'd1) begin testsFailed++; $display("[TB] FAIL single_count_n: got %0d expected 1", fifoCount); end
      tick();
      testsRun++; if (busy !== 1'b1 || bus.arm_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_load: busy %b req %b expected 1 0", busy, bus.arm_req); end
      tick();
      testsRun++; if (bus.arm_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_req_n2: got %b expected 1", bus.arm_req); end
      testsRun++; if (fifoCount !== 3'd0) begin testsFailed++; $display("[TB] FAIL single_count_n2: got %0d expected 0", fifoCount); end
      exp = expQ.pop_front();
      got = {bus.arm_x, bus.arm_y, bus.arm_wh, bus.arm_color, bus.arm_angle};
      testsRun++; if (got !== exp) begin testsFailed++; $display("[TB] FAIL single_fields: got %h expected %h", got, exp); end
      bus.arm_ack = 1'b1;
      tick();
      bus.arm_ack = 1'b0;
      testsRun++; if (bus.arm_req !== 1'b0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_ack: req %b busy %b expected 0 1", bus.arm_req, busy); end
      tick();
      bus.arm_done = 1'b1;
      tick();
      bus.arm_done = 1'b0;
      testsRun++; if (busy !== 1'b0 || fifoCount !== 3'd0) begin testsFailed++; $display("[TB] FAIL single_done: busy %b count %0d expected 0 0", busy, fifoCount); end
   endtask

   task automatic test_overflow();
      for (int wh = 1; wh <= 6; wh++) begin
         applyStimulus(mkFrame(9'(16 + wh), 8'(32 + wh), 4'(wh), 4'(wh), 12'(256 + wh)),
                       wh <= 5, wh == 6);
      end
      testsRun++; if (fifoCount !== 3'd4) begin testsFailed++; $display("[TB] FAIL overflow_count: got %0d expected 4", fifoCount); end
      testsRun++; if (dropCnt !== 8'(expDrop)) begin testsFailed++; $display("[TB] FAIL overflow_drop: got %0d expected %0d", dropCnt, expDrop); end
      for (int j = 0; j < 5; j++) serviceJob("overflow");
      testsRun++; if (busy !== 1'b0 || fifoCount !== 3'd0) begin testsFailed++; $display("[TB] FAIL overflow_drain: busy %b count %0d expected 0 0", busy, fifoCount); end
   endtask

   task automatic test_push_pop_full();
      bit     ok;
      frame_t exp, got;
      applyStimulus(mkFrame(9'h0A1, 8'h11, 4'd7, 4'd1, 12'h011), 1'b1, 1'b0);
      waitReq(ok);
      exp = expQ.pop_front();
      got = {bus.arm_x, bus.arm_y, bus.arm_wh, bus.arm_color, bus.arm_angle};
      testsRun++; if (!ok || got !== exp) begin testsFailed++; $display("[TB] FAIL full_first: req %b got %h expected %h", ok, got, exp); end
      bus.arm_ack = 1'b1;
      tick();
      bus.arm_ack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(mkFrame(9'(160 + k), 8'h22, 4'(8 + k), 4'(k), 12'(k)), 1'b1, 1'b0);
      end
      testsRun++; if (fifoCount !== 3'd4) begin testsFailed++; $display("[TB] FAIL full_fill: got %0d expected 4", fifoCount); end
      bus.arm_done = 1'b1;
      tick();
      bus.arm_done = 1'b0;
      tick();
      applyStimulus(mkFrame(9'h1F0, 8'h33, 4'd12, 4'd5, 12'h555), 1'b0, 1'b1);
      testsRun++; if (fifoCount !== 3'd3) begin testsFailed++; $display("[TB] FAIL full_pushpop_count: got %0d expected 3", fifoCount); end
      testsRun++; if (dropCnt !== 8'(expDrop)) begin testsFailed++; $display("[TB] FAIL full_pushpop_drop: got %0d expected %0d", dropCnt, expDrop); end
      testsRun++; if (bus.arm_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_pushpop_req: got %b expected 1", bus.arm_req); end
      for (int j = 0; j < 4; j++) serviceJob("full_drain");
   endtask

   task automatic test_filters();
      frame_t g;
      applyStimulus(mkFrame(9'h050, 8'h50, 4'd0, 4'd3, 12'h050), 1'b0, 1'b1);
      testsRun++; if (dropCnt !== 8'(expDrop)) begin testsFailed++; $display("[TB] FAIL filter_wh0: got %0d expected %0d", dropCnt, expDrop); end
      g = mkFrame(9'h077, 8'h66, 4'd9, 4'd4, 12'h321);
      applyStimulus(g, 1'b1, 1'b0);
      applyStimulus(g, 1'b0, 1'b1);
      testsRun++; if (dropCnt !== 8'(expDrop)) begin testsFailed++; $display("[TB] FAIL filter_dup: got %0d expected %0d", dropCnt, expDrop); end
      serviceJob("filter_first");
      applyStimulus(g, 1'b1, 1'b0);
      testsRun++; if (dropCnt !== 8'(expDrop) || fifoCount !== 3'd1) begin testsFailed++; $display("[TB] FAIL filter_requeue: drop %0d count %0d expected %0d 1", dropCnt, fifoCount, expDrop); end
      serviceJob("filter_requeue");
      enable = 1'b0;
      applyStimulus(mkFrame(9'h0EE, 8'h0E, 4'd14, 4'd14, 12'h0EE), 1'b0, 1'b0);
      repeat (3) tick();
      testsRun++; if (fifoCount !== 3'd0 || busy !== 1'b0 || dropCnt !== 8'(expDrop)) begin testsFailed++; $display("[TB] FAIL filter_disabled: count %0d busy %b drop %0d expected 0 0 %0d", fifoCount, busy, dropCnt, expDrop); end
      enable = 1'b1;
   endtask

   task automatic test_timeout();
      bit     ok;
      int     early;
      frame_t exp, got;
      applyStimulus(mkFrame(9'h101, 8'h71, 4'd5, 4'd6, 12'h777), 1'b1, 1'b0);
      applyStimulus(mkFrame(9'h102, 8'h72, 4'd6, 4'd7, 12'h888), 1'b1, 1'b0);
      waitReq(ok);
      exp = expQ.pop_front();
      got = {bus.arm_x, bus.arm_y, bus.arm_wh, bus.arm_color, bus.arm_angle};
      testsRun++; if (!ok || got !== exp) begin testsFailed++; $display("[TB] FAIL timeout_job: req %b got %h expected %h", ok, got, exp); end
      bus.arm_ack = 1'b1;
      tick();
      bus.arm_ack = 1'b0;
      early = 0;
      for (int k = 1; k < int'(TIMEOUT_CYC); k++) begin
         tick();
         if (timeoutErr !== 1'b0) early++;
      end
      testsRun++; if (early != 0) begin testsFailed++; $display("[TB] FAIL timeout_early: got %0d early pulses expected 0", early); end
      tick();
      testsRun++; if (timeoutErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_pulse: got %b expected 1", timeoutErr); end
      tick();
      testsRun++; if (timeoutErr !== 1'b0 || bus.arm_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_after: err %b req %b expected 0 0", timeoutErr, bus.arm_req); end
      tick();
      testsRun++; if (bus.arm_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_next_req: got %b expected 1", bus.arm_req); end
      serviceJob("timeout_next");
   endtask

   task automatic test_flush();
      bit     ok;
      frame_t exp, got, c2;
      applyStimulus(mkFrame(9'h131, 8'h31, 4'd1, 4'd1, 12'h131), 1'b1, 1'b0);
      waitReq(ok);
      exp = expQ.pop_front();
      got = {bus.arm_x, bus.arm_y, bus.arm_wh, bus.arm_color, bus.arm_angle};
      testsRun++; if (!ok || got !== exp) begin testsFailed++; $display("[TB] FAIL flush_job: req %b got %h expected %h", ok, got, exp); end
      c2 = mkFrame(9'h133, 8'h33, 4'd3, 4'd3, 12'h133);
      applyStimulus(mkFrame(9'h132, 8'h32, 4'd2, 4'd2, 12'h132), 1'b0, 1'b0);
      applyStimulus(c2, 1'b0, 1'b0);
      testsRun++; if (fifoCount !== 3'd2) begin testsFailed++; $display("[TB] FAIL flush_fill: got %0d expected 2", fifoCount); end
      bus.cam_valid = 1'b1; bus.cam_x = 9'h134; bus.cam_y = 8'h34; bus.cam_wh = 4'd4;
      bus.cam_color = 4'd4; bus.cam_angle = 12'h134; flush = 1'b1;
      tick();
      bus.cam_valid = 1'b0; flush = 1'b0;
      testsRun++; if (fifoCount !== 3'd0 || dropCnt !== 8'(expDrop)) begin testsFailed++; $display("[TB] FAIL flush_count: count %0d drop %0d expected 0 %0d", fifoCount, dropCnt, expDrop); end
      testsRun++; if (bus.arm_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_inflight: got %b expected 1", bus.arm_req); end
      bus.arm_ack = 1'b1;
      tick();
      bus.arm_ack = 1'b0;
      tick();
      bus.arm_done = 1'b1;
      tick();
      bus.arm_done = 1'b0;
      applyStimulus(c2, 1'b1, 1'b0);
      testsRun++; if (fifoCount !== 3'd1 || dropCnt !== 8'(expDrop)) begin testsFailed++; $display("[TB] FAIL flush_dup_clear: count %0d drop %0d expected 1 %0d", fifoCount, dropCnt, expDrop); end
      serviceJob("flush_after");
   endtask

   task automatic test_reset_midjob();
      bit ok;
      applyStimulus(mkFrame(9'h1A1, 8'hA1, 4'd10, 4'd2, 12'hA01), 1'b1, 1'b0);
      applyStimulus(mkFrame(9'h1A2, 8'hA2, 4'd11, 4'd3, 12'hA02), 1'b1, 1'b0);
      applyStimulus(mkFrame(9'h1A2, 8'hA2, 4'd11, 4'd3, 12'hA02), 1'b0, 1'b1);
      waitReq(ok);
      bus.arm_ack = 1'b1;
      tick();
      bus.arm_ack = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      testsRun++; if (bus.arm_req !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_ctrl: req %b busy %b expected 0 0", bus.arm_req, busy); end
      testsRun++; if (fifoCount !== 3'd0 || dropCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL midreset_state: count %0d drop %0d expected 0 0", fifoCount, dropCnt); end
      expQ.delete();
      expDrop = 0;
      tick();
      rst_n = 1'b1;
      tick();
      applyStimulus(mkFrame(9'h1A1, 8'hA1, 4'd10, 4'd2, 12'hA01), 1'b1, 1'b0);
      serviceJob("midreset_after");
      testsRun++; if (busy !== 1'b0 || dropCnt !== 8'(expDrop)) begin testsFailed++; $display("[TB] FAIL midreset_final: busy %b drop %0d expected 0 %0d", busy, dropCnt, expDrop); end
   endtask

   // Global guard so a stuck handshake cannot hang the run.
   initial begin
      #500_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] global timeout");
   end

   // Scenario sequence
   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_push_pop_full();
      test_filters();
      test_timeout();
      test_flush();
      test_reset_midjob();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
